// File: rtl/prng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prng_share_ctrl
// Description : Seeds a xoshiro128++ core, discards warm-up outputs,
//               prefetches random words into a small FIFO and hands them out
//               one word per grant to NREQ requesters in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_share_ctrl #(
    parameter int           NREQ   = 4,
    parameter int           DEPTH  = 4,
    parameter int           WARMUP = 8,
    parameter logic [127:0] SEED   = 128'h00000004_00000003_00000002_00000001
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reseed,
    input  logic [127:0]             seed_in,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     core_write,
    output logic [1:0]               core_waddr,
    output logic [31:0]              core_wdata,
    output logic                     core_next,
    input  logic [31:0]              core_rnd
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam int                c_pw       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_aw:0]     c_depth    = (c_aw+1)'(DEPTH);
    localparam logic [c_pw:0]     c_nreq     = (c_pw+1)'(NREQ);
    localparam logic [c_pw-1:0]   c_last_req = c_pw'(NREQ-1);
    localparam logic [7:0]        c_warm_last = 8'(WARMUP-1);

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [127:0]      r_seed;
    logic [31:0]       r_fifo [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_level;
    logic [c_pw-1:0]   r_rr_ptr;

    logic              w_active;
    logic              w_found;
    logic              w_pop;
    logic              w_push;
    logic [c_pw-1:0]   w_gnt_idx;
    logic [c_pw:0]     w_idx_sum;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx_sum = {1'b0, r_rr_ptr} + (c_pw+1)'(i);
            if (w_idx_sum >= c_nreq) begin
                w_idx_sum = w_idx_sum - c_nreq;
            end
            if (!w_found && req[w_idx_sum[c_pw-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx_sum[c_pw-1:0];
            end
        end
    end

    // Handshake and core strobes; reset and reseed suppress every action.
    always_comb begin
        w_active   = rst_n && !reseed;
        w_pop      = w_active && (r_state == ST_RUN) && (r_level != '0) && w_found;
        w_push     = w_active && (r_state == ST_RUN) && ((r_level < c_depth) || w_pop);
        gnt        = '0;
        if (w_pop) begin
            gnt[w_gnt_idx] = 1'b1;
        end
        core_write = w_active && (r_state == ST_SEED);
        core_waddr = core_write ? r_cnt[1:0] : 2'd0;
        core_wdata = core_write ? r_seed[{r_cnt[1:0], 5'd0} +: 32] : 32'd0;
        core_next  = w_push || (w_active && (r_state == ST_WARM));
        busy       = (r_state != ST_RUN);
        level      = r_level;
        rdata      = r_fifo[r_rd_ptr];
    end

    // Next-state logic: SEED walks 4 addresses, WARM counts WARMUP steps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (reseed) begin
            w_state_nxt = ST_SEED;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                ST_SEED: begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = (WARMUP > 0) ? ST_WARM : ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_WARM: begin
                    if (r_cnt == c_warm_last) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    w_state_nxt = ST_SEED;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SEED;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Active seed, FIFO pointers/occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seed   <= SEED;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rr_ptr <= '0;
        end else if (reseed) begin
            r_seed   <= seed_in;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
                r_rr_ptr <= (w_gnt_idx == c_last_req) ? '0 : w_gnt_idx + c_pw'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (c_aw+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (c_aw+1)'(1);
            end
        end
    end

    // FIFO storage; words land in generation order.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= core_rnd;
        end
    end

endmodule
`default_nettype wire
